// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive path.
package tdm_pkg;
    typedef enum logic {HUNT, RECV} state_t;

    localparam int DEF_NCH = 8;

    // The counter must be able to hold NCH, which is the parity slot when that is enabled.
    function automatic int slot_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/demux_1a8.sv
// Slot-to-one-hot write-enable decoder. It is the inverse of the 8:1 serializer mux.
// Selector values at or beyond NCH produce no enable.
module demux_1a8 #(
    parameter int NCH    = 8,
    parameter int SLOT_W = 4
) (
    input  logic              i_en,
    input  logic [SLOT_W-1:0] i_sel,
    output logic [NCH-1:0]    o_we
);
    always_comb begin
        o_we = '0;
        for (int i = 0; i < NCH; i++) begin
            if (i_en && (i_sel == SLOT_W'(i)))
                o_we[i] = 1'b1;
        end
    end
endmodule

// File: rtl/tdm_demux_1a8.sv
// Serial TDM line to NCH parallel channels, with frame lock and sync checking.
// Optional feature macro: TDM_PARITY_EN (adds an even-parity slot after the data slots).
module tdm_demux_1a8
    import tdm_pkg::*;
#(
    parameter  int NCH    = DEF_NCH,
    localparam int SLOT_W = slot_width(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync,
    input  logic              din,
    output logic [NCH-1:0]    y,
    output logic              frame_valid,
    output logic              sync_err,
    output logic              locked,
    output logic [SLOT_W-1:0] slot
`ifdef TDM_PARITY_EN
    ,
    output logic              parity_err
`endif
);
`ifdef TDM_PARITY_EN
    localparam int LAST = NCH;
`else
    localparam int LAST = NCH - 1;
`endif

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic [NCH-1:0]      r_buf;
    logic [NCH-1:0]      r_y;
    logic                r_fv;
    logic                r_serr;
    logic                r_locked;

    logic                w_slot0;
    logic                w_wr_go;
    logic [SLOT_W-1:0]   w_wr_sel;
    logic [NCH-1:0]      w_we;
    logic [NCH-1:0]      w_buf_nxt;

    assign w_slot0 = (r_slot == '0);
    // Any sync restarts at slot 0; a missing sync at slot 0 writes nothing.
    assign w_wr_go  = en & ((r_state == HUNT) ? sync : (sync | ~w_slot0));
    assign w_wr_sel = sync ? '0 : r_slot;

    demux_1a8 #(.NCH(NCH), .SLOT_W(SLOT_W)) u_dec (
        .i_en  (w_wr_go),
        .i_sel (w_wr_sel),
        .o_we  (w_we)
    );

    always_comb begin
        w_buf_nxt = r_buf;
        for (int i = 0; i < NCH; i++)
            if (w_we[i]) w_buf_nxt[i] = din;
    end

`ifdef TDM_PARITY_EN
    logic r_perr;
    assign parity_err = r_perr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= HUNT;
            r_slot   <= '0;
            r_buf    <= '0;
            r_y      <= '0;
            r_fv     <= 1'b0;
            r_serr   <= 1'b0;
            r_locked <= 1'b0;
`ifdef TDM_PARITY_EN
            r_perr   <= 1'b0;
`endif
        end else begin
            r_fv   <= 1'b0;
            r_serr <= 1'b0;
`ifdef TDM_PARITY_EN
            r_perr <= 1'b0;
`endif
            r_buf  <= w_buf_nxt;
            if (en) begin
                case (r_state)
                    HUNT: begin
                        if (sync) begin
                            r_slot  <= SLOT_W'(1);
                            r_state <= RECV;
                        end
                    end
                    RECV: begin
                        if (sync) begin
                            r_slot <= SLOT_W'(1);
                            if (!w_slot0) begin
                                r_serr   <= 1'b1;
                                r_locked <= 1'b0;
                            end
                        end else if (w_slot0) begin
                            r_serr   <= 1'b1;
                            r_locked <= 1'b0;
                            r_state  <= HUNT;
                        end else if (r_slot == SLOT_W'(LAST)) begin
                            r_slot <= '0;
`ifdef TDM_PARITY_EN
                            if (^{din, r_buf} == 1'b0) begin
                                r_y      <= r_buf;
                                r_fv     <= 1'b1;
                                r_locked <= 1'b1;
                            end else begin
                                r_perr   <= 1'b1;
                            end
`else
                            r_y      <= w_buf_nxt;
                            r_fv     <= 1'b1;
                            r_locked <= 1'b1;
`endif
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign y           = r_y;
    assign frame_valid = r_fv;
    assign sync_err    = r_serr;
    assign locked      = r_locked;
    assign slot        = r_slot;
endmodule

// File: tb/tb_tdm_demux_1a8.sv
// Scoreboard bench for tdm_demux_1a8: expected frames are queued as they are sent,
// a negedge monitor pops one per frame_valid pulse.
module tb_tdm_demux_1a8;
    logic       clk = 1'b0;
    logic       reset;
    logic       en, sync, din;
    logic [7:0] y;
    logic       frame_valid, sync_err, locked;
    logic [3:0] slot;
`ifdef TDM_PARITY_EN
    logic       parity_err;
    int         n_perr = 0;
`endif

    int npass = 0;
    int ntot  = 0;
    int n_fv  = 0;
    int n_serr = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    tdm_demux_1a8 #(.NCH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .sync        (sync),
        .din         (din),
        .y           (y),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked),
        .slot        (slot)
`ifdef TDM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every frame_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid) begin
                n_fv++;
                if (exp_q.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_frame: got y=%0h expected no frame", y);
                end else begin
                    chk("frame_y", 32'(y), 32'(exp_q.pop_front()));
                end
            end
            if (sync_err) n_serr++;
`ifdef TDM_PARITY_EN
            if (parity_err) n_perr++;
`endif
        end
    end

    task automatic slot_cyc(input logic s, input logic d);
        @(negedge clk);
        en = 1'b1; sync = s; din = d;
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0; sync = 1'b0; din = 1'b0;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    // Sends a full frame; with parity enabled, appends a parity slot (inverted when bad).
    task automatic send_frame(input logic [7:0] data, input bit gaps, input bit bad_par);
        for (int i = 0; i < 8; i++) begin
            slot_cyc(i == 0, data[i]);
            if (gaps) idle();
        end
`ifdef TDM_PARITY_EN
        slot_cyc(1'b0, (^data) ^ bad_par);
`endif
    endtask

    initial begin
        int fv0, se0;
        reset = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
        #12;
        chk("reset_y", 32'(y), 32'h0);
        chk("reset_locked", 32'(locked), 32'h0);
        chk("reset_slot", 32'(slot), 32'h0);
        chk("reset_fv", 32'(frame_valid), 32'h0);
        @(negedge clk); reset = 1'b0;

        // 1: single frame, slots 1,0,1,1,0,0,1,0
        exp_q.push_back(8'h4D);
        send_frame(8'h4D, 1'b0, 1'b0);
        post_edge();
        chk("t1_fv", 32'(frame_valid), 32'h1);
        chk("t1_y", 32'(y), 32'h4D);
        chk("t1_locked", 32'(locked), 32'h1);
        chk("t1_slot", 32'(slot), 32'h0);
        idle();
        post_edge();
        chk("t1_fv_one_cycle", 32'(frame_valid), 32'h0);

        // 2: en gaps between slots
        fv0 = n_fv; se0 = n_serr;
        exp_q.push_back(8'h4D);
        send_frame(8'h4D, 1'b1, 1'b0);
        idle(); idle();
        chk("t2_fv_count", 32'(n_fv - fv0), 32'h1);
        chk("t2_no_sync_err", 32'(n_serr - se0), 32'h0);
        chk("t2_y", 32'(y), 32'h4D);

        // 3: early sync at slot 5, new frame A5 starts there
        se0 = n_serr;
        for (int i = 0; i < 5; i++) slot_cyc(i == 0, 1'b0);
        exp_q.push_back(8'hA5);
        slot_cyc(1'b1, 1'b1);
        post_edge();
        chk("t3_sync_err", 32'(sync_err), 32'h1);
        chk("t3_locked", 32'(locked), 32'h0);
        chk("t3_y_held", 32'(y), 32'h4D);
        chk("t3_slot", 32'(slot), 32'h1);
        for (int i = 1; i < 8; i++) slot_cyc(1'b0, (8'hA5 >> i) & 8'h1);
`ifdef TDM_PARITY_EN
        slot_cyc(1'b0, ^8'hA5);
`endif
        idle(); idle();
        chk("t3_sync_err_once", 32'(n_serr - se0), 32'h1);
        chk("t3_y_new", 32'(y), 32'hA5);
        chk("t3_relocked", 32'(locked), 32'h1);

        // 4: missing sync at slot 0, then garbage is ignored
        slot_cyc(1'b0, 1'b1);
        post_edge();
        chk("t4_sync_err", 32'(sync_err), 32'h1);
        chk("t4_locked", 32'(locked), 32'h0);
        chk("t4_slot", 32'(slot), 32'h0);
        fv0 = n_fv;
        for (int i = 0; i < 12; i++) slot_cyc(1'b0, 1'(i & 1));
        idle(); idle();
        chk("t4_no_frame", 32'(n_fv - fv0), 32'h0);
        chk("t4_slot_hunt", 32'(slot), 32'h0);
        chk("t4_y_held", 32'(y), 32'hA5);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(); idle();

        // 5: async reset mid-frame at slot 4
        for (int i = 0; i < 4; i++) slot_cyc(i == 0, 1'b1);
        post_edge();
        chk("t5_slot_before", 32'(slot), 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_y", 32'(y), 32'h0);
        chk("t5_rst_locked", 32'(locked), 32'h0);
        chk("t5_rst_slot", 32'(slot), 32'h0);
        chk("t5_rst_pulses", 32'({frame_valid, sync_err}), 32'h0);
        @(negedge clk); reset = 1'b0; en = 1'b0; sync = 1'b0;
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b0, 1'b0);
        idle(); idle();
        chk("t5_y_after", 32'(y), 32'h96);

`ifdef TDM_PARITY_EN
        // 6: good then bad parity
        exp_q.push_back(8'h4D);
        send_frame(8'h4D, 1'b0, 1'b0);
        idle(); idle();
        chk("t6_good_y", 32'(y), 32'h4D);
        fv0 = n_fv;
        send_frame(8'h4D, 1'b0, 1'b1);
        post_edge();
        chk("t6_parity_err", 32'(parity_err), 32'h1);
        idle(); idle();
        chk("t6_no_fv", 32'(n_fv - fv0), 32'h0);
        chk("t6_y_held", 32'(y), 32'h4D);
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
